// File: rtl/fuel_dispenser.sv
// fuel_dispenser: pump-side metering controller.
// Runs the pump for a latched grade/target and counts flow-meter pulses into delivered
// volume (mL) and cost (VND). Stops on target reached, nozzle hang-up or flow stall.
// Ports:
//   clk, reset (async, active-low)
//   start       one-cycle request, latches select/lit_target (IDLE only)
//   select      one-hot grade: 1 = RON92, 2 = RON95, 4 = E5
//   lit_target  volume to deliver, mL
//   stop        nozzle hung up, level-sensitive
//   clear       DONE/FAULT -> IDLE
//   flow_pulse  asynchronous flow-meter pulse
//   pump_on, busy, done, fault   registered status
//   lit_out, cost_out            delivered volume (mL) and cost (VND)
module fuel_dispenser #(
    parameter int unsigned ML_PER_PULSE   = 10,
    parameter int unsigned PRICE_RON92    = 31110,
    parameter int unsigned PRICE_RON95    = 32370,
    parameter int unsigned PRICE_E5       = 31110,
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  select,
    input  logic [23:0] lit_target,
    input  logic        stop,
    input  logic        clear,
    input  logic        flow_pulse,
    output logic        pump_on,
    output logic        busy,
    output logic        done,
    output logic        fault,
    output logic [23:0] lit_out,
    output logic [23:0] cost_out
);

    // Per-pulse cost split into whole VND (Q) and thousandths (R), so that
    // cost_out tracks floor(lit_out * price / 1000) without a divider.
    localparam int unsigned PROD_92 = ML_PER_PULSE * PRICE_RON92;
    localparam int unsigned PROD_95 = ML_PER_PULSE * PRICE_RON95;
    localparam int unsigned PROD_E5 = ML_PER_PULSE * PRICE_E5;
    localparam logic [23:0] Q_92    = 24'(PROD_92 / 1000);
    localparam logic [23:0] Q_95    = 24'(PROD_95 / 1000);
    localparam logic [23:0] Q_E5    = 24'(PROD_E5 / 1000);
    localparam logic [10:0] R_92    = 11'(PROD_92 % 1000);
    localparam logic [10:0] R_95    = 11'(PROD_95 % 1000);
    localparam logic [10:0] R_E5    = 11'(PROD_E5 % 1000);
    localparam logic [23:0] ML_STEP = 24'(ML_PER_PULSE);
    localparam logic [25:0] TMO_LAST = 26'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StPumping, StDone, StFault} state_e;

    state_e      state_q, state_d;
    logic [2:0]  grade_q, grade_d;
    logic [23:0] target_q, target_d;
    logic [23:0] lit_q, lit_d;
    logic [23:0] cost_q, cost_d;
    logic [9:0]  rem_q, rem_d;
    logic [25:0] tmo_q, tmo_d;
    logic        sync1_q, sync2_q, sync3_q;
    logic        pump_on_q, pump_on_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        fault_q, fault_d;

    logic        metered;
    logic [23:0] cost_step;
    logic [10:0] rem_step;
    logic [10:0] rem_sum;
    logic        rem_carry;
    logic [23:0] lit_inc;
    logic [23:0] cost_inc;

    // Two-flop synchronizer plus a third flop for rising-edge detection.
    assign metered = sync2_q & ~sync3_q;

    always_comb begin
        cost_step = '0;
        rem_step  = '0;
        case (grade_q)
            3'd1:    begin cost_step = Q_92; rem_step = R_92; end
            3'd2:    begin cost_step = Q_95; rem_step = R_95; end
            3'd4:    begin cost_step = Q_E5; rem_step = R_E5; end
            default: begin cost_step = '0;   rem_step = '0;   end
        endcase
    end

    assign rem_sum   = {1'b0, rem_q} + rem_step;
    assign rem_carry = (rem_sum >= 11'd1000);
    assign lit_inc   = lit_q + ML_STEP;
    assign cost_inc  = cost_q + cost_step + {23'd0, rem_carry};

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            grade_q   <= '0;
            target_q  <= '0;
            lit_q     <= '0;
            cost_q    <= '0;
            rem_q     <= '0;
            tmo_q     <= '0;
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            sync3_q   <= 1'b0;
            pump_on_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            grade_q   <= grade_d;
            target_q  <= target_d;
            lit_q     <= lit_d;
            cost_q    <= cost_d;
            rem_q     <= rem_d;
            tmo_q     <= tmo_d;
            sync1_q   <= flow_pulse;
            sync2_q   <= sync1_q;
            sync3_q   <= sync2_q;
            pump_on_q <= pump_on_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            fault_q   <= fault_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d  = state_q;
        grade_d  = grade_q;
        target_d = target_q;
        lit_d    = lit_q;
        cost_d   = cost_q;
        rem_d    = rem_q;
        tmo_d    = tmo_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    grade_d  = select;
                    target_d = lit_target;
                    lit_d    = '0;
                    cost_d   = '0;
                    rem_d    = '0;
                    tmo_d    = '0;
                    if (!(select inside {3'd1, 3'd2, 3'd4})) begin
                        state_d = StFault;
                    end else if (lit_target == 24'd0) begin
                        state_d = StDone;
                    end else begin
                        state_d = StPumping;
                    end
                end
            end
            StPumping: begin
                if (metered) begin
                    lit_d  = lit_inc;
                    cost_d = cost_inc;
                    rem_d  = rem_carry ? 10'(rem_sum - 11'd1000) : rem_sum[9:0];
                    tmo_d  = '0;
                end else begin
                    tmo_d  = tmo_q + 26'd1;
                end
                // Pulse is counted even when stop arrives in the same cycle.
                if (stop) begin
                    state_d = StDone;
                end else if (metered && (lit_inc >= target_q)) begin
                    state_d = StDone;
                end else if (!metered && (tmo_q == TMO_LAST)) begin
                    state_d = StFault;
                end
            end
            StDone, StFault: begin
                if (clear) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Status outputs decoded from the next state so they register with it.
    always_comb begin
        pump_on_d = (state_d == StPumping);
        busy_d    = (state_d == StPumping);
        done_d    = (state_d == StDone);
        fault_d   = (state_d == StFault);
    end

    assign pump_on  = pump_on_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign fault    = fault_q;
    assign lit_out  = lit_q;
    assign cost_out = cost_q;

endmodule

// File: tb/tb_fuel_dispenser.sv
module tb_fuel_dispenser;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  select;
    logic [23:0] lit_target;
    logic        stop;
    logic        clear;
    logic        flow_pulse;
    logic        pump_on;
    logic        busy;
    logic        done;
    logic        fault;
    logic [23:0] lit_out;
    logic [23:0] cost_out;

    int errors = 0;
    int checks = 0;

    fuel_dispenser #(
        .ML_PER_PULSE   (10),
        .PRICE_RON92    (31110),
        .PRICE_RON95    (32370),
        .PRICE_E5       (31110),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .select     (select),
        .lit_target (lit_target),
        .stop       (stop),
        .clear      (clear),
        .flow_pulse (flow_pulse),
        .pump_on    (pump_on),
        .busy       (busy),
        .done       (done),
        .fault      (fault),
        .lit_out    (lit_out),
        .cost_out   (cost_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_start(input logic [2:0] sel, input logic [23:0] tgt);
        @(negedge clk);
        select     = sel;
        lit_target = tgt;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    // High 3 cycles, low 3 cycles; counts are updated by the end.
    task automatic do_pulse();
        @(negedge clk);
        flow_pulse = 1'b1;
        repeat (3) @(negedge clk);
        flow_pulse = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        reset      = 1'b0;
        start      = 1'b0;
        select     = 3'd0;
        lit_target = '0;
        stop       = 1'b0;
        clear      = 1'b0;
        flow_pulse = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_pump", {31'd0, pump_on}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_lit", {8'd0, lit_out}, 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // 1: RON92, target 100, 10 pulses; check update latency on the last one.
        do_start(3'd1, 24'd100);
        check("t1_busy", {31'd0, busy}, 32'd1);
        check("t1_pump", {31'd0, pump_on}, 32'd1);
        repeat (9) do_pulse();
        check("t1_lit9", {8'd0, lit_out}, 32'd90);
        check("t1_cost9", {8'd0, cost_out}, 32'd2799);
        @(negedge clk);
        flow_pulse = 1'b1;
        @(negedge clk);
        check("t1_lat1", {8'd0, lit_out}, 32'd90);
        @(negedge clk);
        check("t1_lat2", {8'd0, lit_out}, 32'd90);
        check("t1_lat2_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("t1_lit", {8'd0, lit_out}, 32'd100);
        check("t1_cost", {8'd0, cost_out}, 32'd3111);
        check("t1_done", {31'd0, done}, 32'd1);
        check("t1_pump_off", {31'd0, pump_on}, 32'd0);
        flow_pulse = 1'b0;
        repeat (3) @(negedge clk);
        do_clear();
        check("t1_clr_done", {31'd0, done}, 32'd0);
        check("t1_clr_lit", {8'd0, lit_out}, 32'd100);

        // 2: RON95, target 25, overshoot to 30.
        do_start(3'd2, 24'd25);
        check("t2_lit0", {8'd0, lit_out}, 32'd0);
        do_pulse();
        check("t2_cost1", {8'd0, cost_out}, 32'd323);
        do_pulse();
        check("t2_cost2", {8'd0, cost_out}, 32'd647);
        check("t2_busy2", {31'd0, busy}, 32'd1);
        do_pulse();
        check("t2_cost3", {8'd0, cost_out}, 32'd971);
        check("t2_lit", {8'd0, lit_out}, 32'd30);
        check("t2_done", {31'd0, done}, 32'd1);
        do_clear();

        // 3: invalid grade.
        do_start(3'd3, 24'd500);
        check("t3_fault", {31'd0, fault}, 32'd1);
        check("t3_pump", {31'd0, pump_on}, 32'd0);
        check("t3_lit", {8'd0, lit_out}, 32'd0);
        do_clear();
        check("t3_clr_fault", {31'd0, fault}, 32'd0);
        check("t3_clr_busy", {31'd0, busy}, 32'd0);

        // 4: E5, target 1000, 4 pulses then stop; later pulse ignored.
        do_start(3'd4, 24'd1000);
        repeat (4) do_pulse();
        check("t4_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("t4_done", {31'd0, done}, 32'd1);
        check("t4_pump", {31'd0, pump_on}, 32'd0);
        check("t4_lit", {8'd0, lit_out}, 32'd40);
        check("t4_cost", {8'd0, cost_out}, 32'd1244);
        do_pulse();
        check("t4_post_lit", {8'd0, lit_out}, 32'd40);
        check("t4_post_cost", {8'd0, cost_out}, 32'd1244);
        do_clear();

        // 5: timeout with no pulses; second start in PUMPING ignored.
        do_start(3'd1, 24'd500);
        for (int i = 0; i < 99; i++) begin
            @(negedge clk);
            if (i == 49) begin
                select     = 3'd3;
                lit_target = 24'd0;
                start      = 1'b1;
            end else begin
                start      = 1'b0;
            end
        end
        check("t5_busy99", {31'd0, busy}, 32'd1);
        check("t5_fault99", {31'd0, fault}, 32'd0);
        @(negedge clk);
        check("t5_fault", {31'd0, fault}, 32'd1);
        check("t5_pump", {31'd0, pump_on}, 32'd0);
        check("t5_lit", {8'd0, lit_out}, 32'd0);
        check("t5_cost", {8'd0, cost_out}, 32'd0);
        do_clear();

        // 6: reset mid-PUMPING, then zero target.
        do_start(3'd1, 24'd1000);
        repeat (5) do_pulse();
        check("t6_lit5", {8'd0, lit_out}, 32'd50);
        check("t6_cost5", {8'd0, cost_out}, 32'd1555);
        #2;
        reset = 1'b0;
        #1;
        check("t6_rst_pump", {31'd0, pump_on}, 32'd0);
        check("t6_rst_busy", {31'd0, busy}, 32'd0);
        check("t6_rst_lit", {8'd0, lit_out}, 32'd0);
        check("t6_rst_cost", {8'd0, cost_out}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        do_start(3'd1, 24'd0);
        check("t6_zero_done", {31'd0, done}, 32'd1);
        check("t6_zero_pump", {31'd0, pump_on}, 32'd0);
        check("t6_zero_lit", {8'd0, lit_out}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fuel_dispenser.md
# fuel_dispenser

Pump-side metering controller for the fuel station. It takes the millilitre target and fuel grade produced by the price calculation stage, runs the pump, and counts flow-meter pulses into delivered volume (mL) and delivered cost (VND). It stops the pump when the target is reached, when the nozzle is hung up, or when flow stalls. Its outputs drive the pump relay and the live volume/cost display.

## Interface
- `ML_PER_PULSE`, 10: millilitres per flow-meter pulse.
- `PRICE_RON92`, 31110: VND per litre, select = 1.
- `PRICE_RON95`, 32370: VND per litre, select = 2.
- `PRICE_E5`, 31110: VND per litre, select = 4.
- `TIMEOUT_CYCLES`, 50_000_000: maximum clk cycles without a pulse while pumping.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  asynchronous, active-low; clears all state.
- `start`  in  1  one-cycle request; latches `select` and `lit_target`.
- `select`  in  3  fuel grade, one-hot: 1, 2 or 4.
- `lit_target`  in  24  volume to deliver, in mL.
- `stop`  in  1  nozzle hung up; level-sensitive.
- `clear`  in  1  returns DONE/FAULT to IDLE.
- `flow_pulse`  in  1  asynchronous pulse from the flow meter.
- `pump_on`  out  1  pump relay enable.
- `busy`  out  1  high in PUMPING.
- `done`  out  1  high in DONE.
- `fault`  out  1  high in FAULT.
- `lit_out`  out  24  delivered volume, in mL.
- `cost_out`  out  24  delivered cost, in VND.

## Operation
- FSM states: IDLE, PUMPING, DONE, FAULT. All outputs are registered.
- **IDLE**
  - On `start`: latch grade and target, clear `lit_out`, `cost_out`, the remainder and the timeout counter.
  - Invalid grade (not 1/2/4) -> FAULT.
  - `lit_target` == 0 -> DONE.
  - Otherwise -> PUMPING.
- **PUMPING**
  - `pump_on` = 1.
  - Each metered pulse adds `ML_PER_PULSE` to `lit_out` and updates cost.
  - Transitions, by priority:
    1. `stop` -> DONE.
    2. `lit_out` >= target after the update -> DONE.
    3. Timeout counter reaches `TIMEOUT_CYCLES` -> FAULT.
  - The timeout counter clears on every metered pulse.
- **DONE / FAULT**
  - `pump_on` = 0; `lit_out` and `cost_out` hold for display.
  - `clear` -> IDLE; counts stay visible until the next `start`.
- `start` is ignored outside IDLE. `clear` is ignored in IDLE and PUMPING.
- **Cost arithmetic** (exact, divider-free):
  - Constants are computed at elaboration: Q = (`ML_PER_PULSE` * price) / 1000 and R = (`ML_PER_PULSE` * price) mod 1000.
  - Per pulse: `cost_out` += Q; rem += R. If rem >= 1000, then rem -= 1000 and `cost_out` += 1.
  - R < 1000 guarantees a single correction per pulse.
  - Result is always `cost_out` = floor(`lit_out` * price / 1000).
- Overshoot: the final pulse may exceed the target by up to `ML_PER_PULSE` - 1 mL. `lit_out` and `cost_out` report the actual delivery, not the target.
- Widths: `lit_out` and `cost_out` are 24 bits; rem is 10 bits; the timeout counter is 26 bits. Stopping at target keeps the counters far below overflow.

## Timing
- Reset values: state IDLE; `pump_on`, `busy`, `done`, `fault` = 0; `lit_out`, `cost_out`, rem and the timeout counter = 0.
- Reset applies immediately, mid-operation included; `pump_on` drops asynchronously.
- `start` sampled at edge N: state/`busy`/`pump_on` valid after edge N.
- Pulse path:
  - `flow_pulse` passes through a 2-flop synchronizer, then a registered rising-edge detect.
  - `lit_out`/`cost_out` update at the 3rd clk edge after `flow_pulse` rises.
  - Pulses must be high and low for at least 2 clk cycles each.
- Target reached: the same edge that updates `lit_out` moves the state to DONE. `pump_on` is low in the following cycle.
- Simultaneous `stop` and a metered pulse: the pulse is counted, then the state goes to DONE.
- Pulses arriving in DONE/FAULT are ignored, as is any residual flow.

## Test plan
1. Grade 1, target 100, 10 pulses -> `lit_out` = 100, `cost_out` = 3111, `done` = 1, `pump_on` = 0 one cycle after the 10th update.
2. Grade 2, target 25, 3 pulses -> `cost_out` after each pulse 323, 647, 971; `lit_out` = 30; DONE.
3. Grade 3 on `start` -> FAULT, `pump_on` never asserted. Then `clear` -> IDLE.
4. Grade 4, target 1000, 4 pulses then `stop` -> DONE with `lit_out` = 40, `cost_out` = 1244. A pulse after `stop` changes nothing.
5. `TIMEOUT_CYCLES` = 100, grade 1, no pulses -> FAULT after 100 cycles, `pump_on` = 0, counts 0. Second `start` during PUMPING is ignored.
6. `reset` low mid-PUMPING after 5 pulses -> `pump_on` = 0 immediately, all outputs 0, state IDLE. Target 0 -> DONE directly with counts 0.
